// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation.
package ascon_pkg;

    typedef logic [63:0] word_t;

    typedef struct packed {
        word_t x0;
        word_t x1;
        word_t x2;
        word_t x3;
        word_t x4;
    } ascon_state_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    localparam logic [3:0] ROUNDS_P6    = 4'd6;
    localparam logic [3:0] ROUNDS_P8    = 4'd8;
    localparam logic [3:0] ROUNDS_P12   = 4'd12;
    localparam logic [3:0] ROUNDS_TOTAL = 4'd12;

    localparam logic [1:0] RND_SEL_P6  = 2'b00;
    localparam logic [1:0] RND_SEL_P8  = 2'b01;
    localparam logic [1:0] RND_SEL_P12 = 2'b10;
    localparam logic [1:0] RND_SEL_RSV = 2'b11;

    localparam int unsigned ROT_X0_M = 19;
    localparam int unsigned ROT_X0_N = 28;
    localparam int unsigned ROT_X1_M = 61;
    localparam int unsigned ROT_X1_N = 39;
    localparam int unsigned ROT_X2_M = 1;
    localparam int unsigned ROT_X2_N = 6;
    localparam int unsigned ROT_X3_M = 10;
    localparam int unsigned ROT_X3_N = 17;
    localparam int unsigned ROT_X4_M = 7;
    localparam int unsigned ROT_X4_N = 41;

    function automatic word_t rc(input logic [3:0] r);
        return {56'b0, 4'hF - r, r};
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // pa always ends on round 11, so the first index is 12 - a.
    function automatic logic [3:0] first_round(input logic [1:0] sel);
        case (sel)
            RND_SEL_P6:              return ROUNDS_TOTAL - ROUNDS_P6;
            RND_SEL_P8:              return ROUNDS_TOTAL - ROUNDS_P8;
            RND_SEL_P12, RND_SEL_RSV: return ROUNDS_TOTAL - ROUNDS_P12;
            default:                 return ROUNDS_TOTAL - ROUNDS_P12;
        endcase
    endfunction

endpackage

// File: rtl/ascon_permutation_iter_round.sv
// One combinational Ascon round: constant addition, bitsliced s-box, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t st_i,
    input  logic [3:0]   rnd,
    output ascon_state_t st_o
);

    word_t a0, a1, a2, a3, a4;
    word_t b0, b1, b2, b3, b4;
    word_t s0, s1, s2, s3, s4;

    // Constant addition folded into the s-box input mixing on x2.
    assign a0 = st_i.x0 ^ st_i.x4;
    assign a1 = st_i.x1;
    assign a2 = st_i.x2 ^ rc(rnd) ^ st_i.x1;
    assign a3 = st_i.x3;
    assign a4 = st_i.x4 ^ st_i.x3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign s0 = b0 ^ b4;
    assign s1 = b1 ^ b0;
    assign s2 = ~b2;
    assign s3 = b3 ^ b2;
    assign s4 = b4;

    assign st_o.x0 = s0 ^ rotr(s0, ROT_X0_M) ^ rotr(s0, ROT_X0_N);
    assign st_o.x1 = s1 ^ rotr(s1, ROT_X1_M) ^ rotr(s1, ROT_X1_N);
    assign st_o.x2 = s2 ^ rotr(s2, ROT_X2_M) ^ rotr(s2, ROT_X2_N);
    assign st_o.x3 = s3 ^ rotr(s3, ROT_X3_M) ^ rotr(s3, ROT_X3_N);
    assign st_o.x4 = s4 ^ rotr(s4, ROT_X4_M) ^ rotr(s4, ROT_X4_N);

endmodule

// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon p^a engine (a = 6/8/12), UNROLL rounds per clock, start/done handshake.
// Optional synchronous cancel input enabled by defining ASCON_PERM_ABORT_EN.
//
//   state  | meaning
//   S_IDLE | waiting for start; x*_o holds last result (or 0 after reset/abort)
//   S_RUN  | applying UNROLL rounds per clock until round index reaches 12
module ascon_permutation_iter
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  rnd_sel,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic        abort,
`endif
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        busy,
    output logic        done
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_permutation_iter: UNROLL must be 1 or 2");
    end

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   r_q, r_d;
    ascon_state_t st_q, st_d;
    logic         done_q, done_d;
    ascon_state_t chain [UNROLL+1];

    assign chain[0] = st_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_round u_round (
            .st_i (chain[k]),
            .rnd  (r_q + 4'(k)),
            .st_o (chain[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            r_q    <= 4'd0;
            st_q   <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            r_q    <= r_d;
            st_q   <= st_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        r_d    = r_q;
        st_d   = st_q;
        done_d = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    st_d  = '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
                    r_d   = first_round(rnd_sel);
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef ASCON_PERM_ABORT_EN
                if (abort) begin
                    st_d  = '0;
                    fsm_d = S_IDLE;
                end else
`endif
                begin
                    st_d = chain[UNROLL];
                    r_d  = r_q + 4'(UNROLL);
                    if (r_d == ROUNDS_TOTAL) begin
                        fsm_d  = S_IDLE;
                        done_d = 1'b1;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign busy = (fsm_q == S_RUN);
    assign done = done_q;
    assign x0_o = st_q.x0;
    assign x1_o = st_q.x1;
    assign x2_o = st_q.x2;
    assign x3_o = st_q.x3;
    assign x4_o = st_q.x4;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Randomized bench: UNROLL=1 and UNROLL=2 instances side by side against a table-driven Ascon model.
module tb_ascon_permutation_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  rnd_sel;
    logic [63:0] x_in [5];
`ifdef ASCON_PERM_ABORT_EN
    logic        abort;
`endif

    logic [63:0] o1 [5];
    logic [63:0] o2 [5];
    logic        busy1, done1, busy2, done2;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned sbox_t [32] = '{8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
                                  8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
                                  8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
                                  8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};
    byte unsigned rc_t [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    int unsigned rot_m [5] = '{19, 61, 1, 10, 7};
    int unsigned rot_n [5] = '{28, 39, 6, 17, 41};

    ascon_permutation_iter #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .rnd_sel(rnd_sel),
        .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
`ifdef ASCON_PERM_ABORT_EN
        .abort(abort),
`endif
        .x0_o(o1[0]), .x1_o(o1[1]), .x2_o(o1[2]), .x3_o(o1[3]), .x4_o(o1[4]),
        .busy(busy1), .done(done1)
    );

    ascon_permutation_iter #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .rnd_sel(rnd_sel),
        .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
`ifdef ASCON_PERM_ABORT_EN
        .abort(abort),
`endif
        .x0_o(o2[0]), .x1_o(o2[1]), .x2_o(o2[2]), .x3_o(o2[3]), .x4_o(o2[4]),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] pack_st(input logic [63:0] x [5]);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int rounds_of(input logic [1:0] sel);
        if (sel == 2'b00) return 6;
        if (sel == 2'b01) return 8;
        return 12;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference p^a: round constant from a table, s-box applied per bit column via lookup.
    function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, sub;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - a; r < 12; r++) begin
            x[2] = x[2] ^ {56'b0, rc_t[r]};
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                sub = sbox_t[col][4:0];
                for (int i = 0; i < 5; i++) y[i][b] = sub[4 - i];
            end
            for (int i = 0; i < 5; i++) x[i] = y[i] ^ ror(y[i], rot_m[i]) ^ ror(y[i], rot_n[i]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < 5; i++) x_in[i] = {$urandom, $urandom};
        rnd_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic present(input logic [1:0] sel, input logic [319:0] st);
        start   = 1'b1;
        rnd_sel = sel;
        for (int i = 0; i < 5; i++) x_in[i] = st[319 - 64*i -: 64];
    endtask

    // Caller has start presented before the next rising edge; returns #1 after the done edge of dut1.
    task automatic run_one(input string name, input logic [1:0] sel, input logic [319:0] st,
                           input bit interfere, input bit chain_next,
                           input logic [1:0] sel2, input logic [319:0] st2);
        int n1, n2;
        logic [319:0] exp;
        n1  = rounds_of(sel);
        n2  = n1 / 2;
        exp = model_perm(st, n1);
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        chk({name, "_load1"}, {busy1, done1}, 2'b10);
        chk({name, "_load2"}, {busy2, done2}, 2'b10);
        for (int k = 1; k <= n1; k++) begin
            if (interfere && k == 3) begin
                start = 1'b1;
                scramble_inputs();
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < n1) chk({name, "_bd1"}, {busy1, done1}, 2'b10);
            else begin
                chk({name, "_done1"}, {busy1, done1}, 2'b01);
                chk({name, "_res1"}, pack_st(o1), exp);
            end
            if (k < n2) chk({name, "_bd2"}, {busy2, done2}, 2'b10);
            else if (k == n2) begin
                chk({name, "_done2"}, {busy2, done2}, 2'b01);
                chk({name, "_res2"}, pack_st(o2), exp);
            end else begin
                chk({name, "_idle2"}, {busy2, done2}, 2'b00);
                chk({name, "_hold2"}, pack_st(o2), exp);
            end
        end
        if (chain_next) present(sel2, st2);
    endtask

    function automatic logic [319:0] rnd_state();
        return {$urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_cycles(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk({name, "_nodone"}, {busy1, done1, busy2, done2}, 4'b0000);
        end
    endtask

    logic [319:0] s_a, s_b;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rnd_sel = 2'b00;
        for (int i = 0; i < 5; i++) x_in[i] = '0;
`ifdef ASCON_PERM_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("rst_flags", {busy1, done1, busy2, done2}, 4'b0000);
        chk("rst_st1", pack_st(o1), '0);
        chk("rst_st2", pack_st(o2), '0);
        @(negedge clk);
        rst_n = 1'b1;
        scramble_inputs();
        idle_cycles("post_rst", 3);
        chk("post_rst_st", {pack_st(o1), pack_st(o2)}, '0);

        // p12 on the initialization-style vector
        @(negedge clk);
        present(2'b10, {64'h80400c0600000000, 256'b0});
        run_one("p12iv", 2'b10, {64'h80400c0600000000, 256'b0}, 1'b0, 1'b0, 2'b00, '0);
        idle_cycles("p12iv", 1);

        // random p6 / p8 / reserved selector
        for (int t = 0; t < 6; t++) begin
            logic [1:0] sel;
            sel = 2'(t % 3 == 2 ? 3 : t % 3);
            s_a = rnd_state();
            @(negedge clk);
            present(sel, s_a);
            run_one($sformatf("rnd%0d", t), sel, s_a, 1'b0, 1'b0, 2'b00, '0);
            idle_cycles($sformatf("rnd%0d", t), 1);
        end

        // start while busy is ignored
        for (int t = 0; t < 3; t++) begin
            logic [1:0] sel;
            sel = 2'(t);
            s_a = rnd_state();
            @(negedge clk);
            present(sel, s_a);
            run_one($sformatf("ign%0d", t), sel, s_a, 1'b1, 1'b0, 2'b00, '0);
            idle_cycles($sformatf("ign%0d", t), 2);
        end

        // back-to-back: start presented in the done cycle
        s_a = rnd_state();
        s_b = rnd_state();
        @(negedge clk);
        present(2'b10, s_a);
        run_one("b2b_a", 2'b10, s_a, 1'b0, 1'b1, 2'b10, s_b);
        run_one("b2b_b", 2'b10, s_b, 1'b0, 1'b0, 2'b00, '0);
        idle_cycles("b2b", 1);

        // async reset mid-run
        s_a = rnd_state();
        @(negedge clk);
        present(2'b01, s_a);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {busy1, done1, busy2, done2}, 4'b0000);
        chk("arst_st", {pack_st(o1), pack_st(o2)}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles("arst", 10);

`ifdef ASCON_PERM_ABORT_EN
        s_a = rnd_state();
        @(negedge clk);
        present(2'b10, s_a);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        chk("abort_flags", {busy1, done1, busy2, done2}, 4'b0000);
        chk("abort_st", {pack_st(o1), pack_st(o2)}, '0);
        idle_cycles("abort", 10);
        @(negedge clk);
        abort = 1'b1;
        idle_cycles("abort_idle", 1);
        abort = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
